// File: rtl/vedic_pkg.sv
// Shared types and the Vedic partial-product helpers used by vedic_8X8 and vedic_dot_acc.
package vedic_pkg;

    typedef logic [7:0]  vedic_op_t;
    typedef logic [15:0] vedic_prod_t;

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } dot_state_e;

    // Urdhva-tiryagbhyam 2x2 cell: vertical/crosswise bit products with a half-adder carry chain.
    function automatic logic [3:0] vedic_2x2(input logic [1:0] x, input logic [1:0] y);
        logic t_cross;
        logic t_top;
        t_cross = (x[1] & y[0]) & (x[0] & y[1]);
        t_top   = x[1] & y[1];
        return {t_top & t_cross, t_top ^ t_cross, (x[1] & y[0]) ^ (x[0] & y[1]), x[0] & y[0]};
    endfunction

    function automatic logic [7:0] vedic_4x4(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] q0, q1, q2, q3;
        q0 = vedic_2x2(x[1:0], y[1:0]);
        q1 = vedic_2x2(x[3:2], y[1:0]);
        q2 = vedic_2x2(x[1:0], y[3:2]);
        q3 = vedic_2x2(x[3:2], y[3:2]);
        return {4'b0, q0} + {2'b0, q1, 2'b0} + {2'b0, q2, 2'b0} + {q3, 4'b0};
    endfunction

endpackage

// File: rtl/vedic_8X8.sv
// Combinational unsigned 8x8 Vedic multiplier built from four 4x4 Vedic blocks.
module vedic_8X8
    import vedic_pkg::*;
(
    input  vedic_op_t   a,
    input  vedic_op_t   b,
    output vedic_prod_t c
);

    logic [7:0] w_q0;
    logic [7:0] w_q1;
    logic [7:0] w_q2;
    logic [7:0] w_q3;

    assign w_q0 = vedic_4x4(a[3:0], b[3:0]);
    assign w_q1 = vedic_4x4(a[7:4], b[3:0]);
    assign w_q2 = vedic_4x4(a[3:0], b[7:4]);
    assign w_q3 = vedic_4x4(a[7:4], b[7:4]);

    assign c = {8'b0, w_q0} + {4'b0, w_q1, 4'b0} + {4'b0, w_q2, 4'b0} + {w_q3, 8'b0};

endmodule

// File: rtl/vedic_dot_acc.sv
// Dot-product accumulator: sums N_TERMS registered Vedic products, result on a valid/ready port.
// Optional macro VEDIC_ACC_SAT_EN: saturate on carry-out and flag out_ovf; otherwise wrap.
module vedic_dot_acc
    import vedic_pkg::*;
#(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  vedic_op_t        a,
    input  vedic_op_t        b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf,
    output dot_state_e       o_dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // ready depends only on the FSM state, never on the partner's valid.

    localparam int              CNT_W = $clog2(N_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_TERMS - 1);

    dot_state_e       r_state;
    vedic_op_t        r_op_a;
    vedic_op_t        r_op_b;
    logic [CNT_W-1:0] r_term_cnt;
    logic             r_p_vld;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;

    vedic_prod_t      w_prod;
    logic             w_accept;
    logic [ACC_W-1:0] w_acc_next;
    logic             w_ovf_next;

    vedic_8X8 u_mul (
        .a(r_op_a),
        .b(r_op_b),
        .c(w_prod)
    );

    assign w_accept = in_valid && (r_state == ST_ACC);

`ifdef VEDIC_ACC_SAT_EN
    logic [ACC_W:0] w_sum;
    always_comb begin
        w_sum      = {1'b0, r_acc} + (ACC_W + 1)'(w_prod);
        w_acc_next = w_sum[ACC_W-1:0];
        w_ovf_next = r_ovf;
        // Once clamped, the sum is pinned at full scale until the result is consumed.
        if (w_sum[ACC_W] || r_ovf) begin
            w_acc_next = '1;
            w_ovf_next = 1'b1;
        end
    end
`else
    always_comb begin
        w_acc_next = r_acc + ACC_W'(w_prod);
        w_ovf_next = 1'b0;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_state    <= ST_ACC;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_term_cnt <= '0;
            r_p_vld    <= 1'b0;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_p_vld <= w_accept;
            if (w_accept) begin
                r_op_a     <= a;
                r_op_b     <= b;
                r_term_cnt <= r_term_cnt + CNT_W'(1);
            end
            if (r_p_vld) begin
                r_acc <= w_acc_next;
                r_ovf <= w_ovf_next;
            end
            case (r_state)
                ST_ACC: begin
                    if (w_accept && (r_term_cnt == LAST)) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state    <= ST_ACC;
                        r_acc      <= '0;
                        r_term_cnt <= '0;
                        r_p_vld    <= 1'b0;
                        r_ovf      <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_ACC;
                end
            endcase
        end
    end

    assign in_ready    = (r_state == ST_ACC);
    assign out_valid   = (r_state == ST_DONE);
    assign out_data    = r_acc;
    assign out_ovf     = r_ovf;
    assign o_dbg_state = r_state;

endmodule
